search_feeder: RTL and testbench

Upstream feeder for the minimum-search unit. It accepts ten 7-bit elements serially over a valid/ready stream and holds them stable on the searcher's parallel inputs A0..A9. It then issues a one-cycle START and waits for Done2, capturing the result (location, cycle count) and acknowledging the searcher with ACK. The captured result goes to the host on a valid/ready result port, with a watchdog guarding against a searcher that never completes.

---
 rtl/search_feeder.sv | 122 ++++++++++++
 tb/tb_search_feeder.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/search_feeder.sv
// search_feeder: loads ten elements serially, presents them in parallel to the
// minimum-search unit, sequences START/Done2/ACK and returns the result to the host.
module search_feeder #(
    parameter int DATA_W  = 7,
    parameter int N_ELEM  = 10,
    parameter int TIMEOUT = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] A0,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] A6,
    output logic [DATA_W-1:0] A7,
    output logic [DATA_W-1:0] A8,
    output logic [DATA_W-1:0] A9,
    output logic              START,
    input  logic              Done2,
    input  logic [3:0]        location,
    input  logic [6:0]        counter2,
    output logic              ACK,
    output logic [3:0]        res_location,
    output logic [6:0]        res_cycles,
    output logic              res_timeout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy
);

    typedef enum logic [2:0] {LOAD, ISSUE, WAIT, ACKN, RESULT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        idx;
    logic [7:0]        wd;
    logic [DATA_W-1:0] a_q [N_ELEM];
    logic              beat;
    logic              last_beat;
    logic              timeout_hit;

    assign beat        = (state == LOAD) && in_valid;
    assign last_beat   = beat && (idx == 4'(N_ELEM - 1));
    assign timeout_hit = (wd == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (last_beat) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                // Done2 takes priority over a watchdog expiring in the same cycle
                if (Done2)            state_nxt = ACKN;
                else if (timeout_hit) state_nxt = RESULT;
            end
            ACKN:    if (!Done2) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx          <= 4'd0;
            wd           <= 8'd0;
            res_location <= 4'd0;
            res_cycles   <= 7'd0;
            res_timeout  <= 1'b0;
            for (int i = 0; i < N_ELEM; i++) a_q[i] <= '0;
        end else begin
            if (beat) idx <= last_beat ? 4'd0 : idx + 4'd1;
            for (int i = 0; i < N_ELEM; i++) begin
                if (beat && idx == 4'(i)) a_q[i] <= in_data;
            end
            if (state == ISSUE) wd <= 8'd0;
            else if (state == WAIT) wd <= wd + 8'd1;
            if (state == WAIT) begin
                if (Done2) begin
                    res_location <= location;
                    res_cycles   <= counter2;
                    res_timeout  <= 1'b0;
                end else if (timeout_hit) begin
                    res_location <= 4'hF;
                    res_cycles   <= 7'h7F;
                    res_timeout  <= 1'b1;
                end
            end
        end
    end

    // Handshake outputs are pure state decodes so they never glitch
    assign in_ready  = (state == LOAD);
    assign START     = (state == ISSUE);
    assign ACK       = (state == ACKN);
    assign res_valid = (state == RESULT);
    assign busy      = (state != LOAD);

    assign A0 = a_q[0];
    assign A1 = a_q[1];
    assign A2 = a_q[2];
    assign A3 = a_q[3];
    assign A4 = a_q[4];
    assign A5 = a_q[5];
    assign A6 = a_q[6];
    assign A7 = a_q[7];
    assign A8 = a_q[8];
    assign A9 = a_q[9];

endmodule

// File: tb/tb_search_feeder.sv
// Self-checking bench for search_feeder: a behavioural searcher plus a model of
// the element array and expected result, under directed and random stimulus.
module tb_search_feeder;
    localparam int DATA_W  = 7;
    localparam int N_ELEM  = 10;
    localparam int TIMEOUT = 200;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] A0, A1, A2, A3, A4, A5, A6, A7, A8, A9;
    logic              START;
    logic              Done2 = 1'b0;
    logic [3:0]        location = 4'd0;
    logic [6:0]        counter2 = 7'd0;
    logic              ACK;
    logic [3:0]        res_location;
    logic [6:0]        res_cycles;
    logic              res_timeout;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_a [N_ELEM];

    search_feeder #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .A5(A5), .A6(A6), .A7(A7), .A8(A8), .A9(A9), .START(START),
        .Done2(Done2), .location(location), .counter2(counter2), .ACK(ACK),
        .res_location(res_location), .res_cycles(res_cycles),
        .res_timeout(res_timeout), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [DATA_W-1:0] dut_a(input int i);
        case (i)
            0: return A0;  1: return A1;  2: return A2;  3: return A3;
            4: return A4;  5: return A5;  6: return A6;  7: return A7;
            8: return A8;  default: return A9;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: in_valid held high, 1: alternating 1,0,1,..., 2: random gaps
    task automatic load_beats(input logic [DATA_W-1:0] vals [N_ELEM], input int mode,
                              output int cycles);
        int beats = 0;
        logic v;
        cycles = 0;
        while (beats < N_ELEM) begin
            case (mode)
                0: v = 1'b1;
                1: v = (cycles % 2 == 0);
                default: v = (cycles > 60) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_data  = v ? vals[beats] : DATA_W'($urandom);
            tick();
            cycles++;
            if (v) begin
                exp_a[beats] = vals[beats];
                beats++;
            end
        end
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
    endtask

    // Searcher: raises Done2 'delay' cycles after START, drops it one cycle after sampling ACK
    task automatic respond(input int delay, input logic [3:0] loc, input logic [6:0] cyc,
                           output int ack_n);
        bit pend = 0;
        ack_n = 0;
        repeat (delay) tick();
        Done2 = 1'b1;
        location = loc;
        counter2 = cyc;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pend) begin
                Done2 = 1'b0;
                location = 4'($urandom);
                counter2 = 7'($urandom);
            end
            if (res_valid) break;
            if (ACK) begin
                ack_n++;
                pend = 1;
            end
        end
        Done2 = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic rand_vals(output logic [DATA_W-1:0] vals [N_ELEM]);
        for (int i = 0; i < N_ELEM; i++) vals[i] = DATA_W'($urandom);
    endtask

    task automatic test_reset();
        logic [DATA_W-1:0] vals [N_ELEM];
        reset = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || START !== 1'b0 || ACK !== 1'b0 ||
            res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b busy=%b START=%b ACK=%b res_valid=%b want 1 0 0 0 0",
                     in_ready, busy, START, ACK, res_valid);
        end
        n_checks++;
        if (res_location !== 4'd0 || res_cycles !== 7'd0 || res_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res: loc=%0d cyc=%0d to=%b want 0 0 0",
                     res_location, res_cycles, res_timeout);
        end
        for (int i = 0; i < N_ELEM; i++) vals[i] = DATA_W'(i + 5);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = vals[i];
            tick();
        end
        in_valid = 1'b0;
        #3 reset = 1'b0;
        #1;
        for (int i = 0; i < N_ELEM; i++) exp_a[i] = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            n_checks++;
            if (dut_a(i) !== exp_a[i]) begin
                n_fail++;
                $display("FAIL reset_async_A%0d: got %0d want 0", i, dut_a(i));
            end
        end
        #2 reset = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [N_ELEM];
        int cyc, ack_n;
        vals = '{7'd50, 7'd40, 7'd30, 7'd20, 7'd10, 7'd60, 7'd70, 7'd80, 7'd90, 7'd100};
        load_beats(vals, 0, cyc);
        n_checks++;
        if (cyc !== 10 || START !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_start: cycles=%0d START=%b in_ready=%b busy=%b want 10 1 0 1",
                     cyc, START, in_ready, busy);
        end
        for (int i = 0; i < N_ELEM; i++) begin
            n_checks++;
            if (dut_a(i) !== exp_a[i]) begin
                n_fail++;
                $display("FAIL b2b_A%0d: got %0d want %0d", i, dut_a(i), exp_a[i]);
            end
        end
        in_valid = 1'b1;
        tick();
        n_checks++;
        if (START !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_pulse: START=%b in_ready=%b want 0 0", START, in_ready);
        end
        in_valid = 1'b0;
        respond(3, 4'd1, 7'd9, ack_n);
        handshake();
    endtask

    task automatic test_toggle_load();
        logic [DATA_W-1:0] vals [N_ELEM];
        int cyc, ack_n;
        rand_vals(vals);
        load_beats(vals, 1, cyc);
        n_checks++;
        if (cyc !== 19 || START !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_start: cycles=%0d START=%b want 19 1", cyc, START);
        end
        for (int i = 0; i < N_ELEM; i++) begin
            n_checks++;
            if (dut_a(i) !== exp_a[i]) begin
                n_fail++;
                $display("FAIL toggle_A%0d: got %0d want %0d", i, dut_a(i), exp_a[i]);
            end
        end
        respond(2, 4'd7, 7'd3, ack_n);
        handshake();
    endtask

    task automatic test_search_done();
        logic [DATA_W-1:0] vals [N_ELEM];
        int cyc, ack_n;
        rand_vals(vals);
        load_beats(vals, 0, cyc);
        respond(20, 4'd4, 7'd20, ack_n);
        n_checks++;
        if (ack_n !== 2) begin
            n_fail++;
            $display("FAIL done_ack_len: got %0d want 2", ack_n);
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_location !== 4'd4 || res_cycles !== 7'd20 ||
            res_timeout !== 1'b0 || ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL done_result: valid=%b loc=%0d cyc=%0d to=%b ACK=%b want 1 4 20 0 0",
                     res_valid, res_location, res_cycles, res_timeout, ACK);
        end
        for (int h = 0; h < 5; h++) begin
            tick();
            n_checks++;
            if (res_valid !== 1'b1 || res_location !== 4'd4 || res_cycles !== 7'd20 ||
                in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL done_hold%0d: valid=%b loc=%0d cyc=%0d in_ready=%b want 1 4 20 0",
                         h, res_valid, res_location, res_cycles, in_ready);
            end
        end
        handshake();
        n_checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_release: in_ready=%b res_valid=%b busy=%b want 1 0 0",
                     in_ready, res_valid, busy);
        end
        for (int i = 0; i < N_ELEM; i++) begin
            n_checks++;
            if (dut_a(i) !== exp_a[i]) begin
                n_fail++;
                $display("FAIL done_A%0d_kept: got %0d want %0d", i, dut_a(i), exp_a[i]);
            end
        end
    endtask

    task automatic test_timeout();
        logic [DATA_W-1:0] vals [N_ELEM];
        int cyc, cnt;
        bit ack_seen = 0;
        rand_vals(vals);
        load_beats(vals, 0, cyc);
        cnt = 0;
        while (!res_valid && cnt < 400) begin
            tick();
            cnt++;
            if (ACK) ack_seen = 1;
        end
        n_checks++;
        if (cnt !== TIMEOUT + 1 || ack_seen) begin
            n_fail++;
            $display("FAIL timeout_latency: cycles=%0d ack_seen=%0d want %0d 0",
                     cnt, ack_seen, TIMEOUT + 1);
        end
        n_checks++;
        if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_location !== 4'hF ||
            res_cycles !== 7'h7F) begin
            n_fail++;
            $display("FAIL timeout_result: valid=%b to=%b loc=%h cyc=%h want 1 1 f 7f",
                     res_valid, res_timeout, res_location, res_cycles);
        end
        handshake();
    endtask

    task automatic test_reset_in_ackn();
        logic [DATA_W-1:0] vals [N_ELEM];
        int cyc, ack_n;
        rand_vals(vals);
        load_beats(vals, 0, cyc);
        repeat (3) tick();
        Done2 = 1'b1;
        location = 4'd2;
        counter2 = 7'd5;
        tick();
        n_checks++;
        if (ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL ackn_entry: ACK=%b want 1", ACK);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ACK !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || res_location !== 4'd0) begin
            n_fail++;
            $display("FAIL ackn_reset: ACK=%b busy=%b in_ready=%b loc=%0d want 0 0 1 0",
                     ACK, busy, in_ready, res_location);
        end
        for (int i = 0; i < N_ELEM; i++) exp_a[i] = '0;
        Done2 = 1'b0;
        #2 reset = 1'b1;
        rand_vals(vals);
        load_beats(vals, 0, cyc);
        respond(6, 4'd9, 7'd33, ack_n);
        n_checks++;
        if (ack_n !== 2 || res_valid !== 1'b1 || res_location !== 4'd9 ||
            res_cycles !== 7'd33 || res_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL ackn_recover: ack=%0d valid=%b loc=%0d cyc=%0d to=%b want 2 1 9 33 0",
                     ack_n, res_valid, res_location, res_cycles, res_timeout);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] vals [N_ELEM];
        logic [3:0] loc;
        logic [6:0] cy;
        int cyc, ack_n, hold;
        for (int it = 0; it < 8; it++) begin
            rand_vals(vals);
            loc = 4'($urandom);
            cy  = 7'($urandom);
            load_beats(vals, 2, cyc);
            n_checks++;
            if (START !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_start: START=%b want 1", it, START);
            end
            respond($urandom_range(0, 30), loc, cy, ack_n);
            n_checks++;
            if (ack_n !== 2 || res_valid !== 1'b1 || res_location !== loc ||
                res_cycles !== cy || res_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_result: ack=%0d valid=%b loc=%0d cyc=%0d want 2 1 %0d %0d",
                         it, ack_n, res_valid, res_location, res_cycles, loc, cy);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) tick();
            handshake();
            for (int i = 0; i < N_ELEM; i++) begin
                n_checks++;
                if (dut_a(i) !== exp_a[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_A%0d: got %0d want %0d", it, i, dut_a(i), exp_a[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N_ELEM; i++) exp_a[i] = '0;
        test_reset();
        test_back_to_back();
        test_toggle_load();
        test_search_done();
        test_timeout();
        test_reset_in_ackn();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
